// File: rtl/unidade_controle_modos_pkg.sv
// Shared definitions for the difficulty-mode game control unit:
// state encodings, the code shown for illegal states and a clog2 helper.
package unidade_controle_modos_pkg;

    typedef enum logic [3:0] {
        INICIAL              = 4'h0,
        PREPARACAO           = 4'h1,
        INICIA_SEQUENCIA     = 4'h2,
        ESPERA_JOGADA        = 4'h3,
        REGISTRA_JOGADA      = 4'h4,
        COMPARA_JOGADA       = 4'h5,
        PROXIMA_JOGADA       = 4'h6,
        FOI_ULTIMA_SEQUENCIA = 4'h7,
        PROXIMA_SEQUENCIA    = 4'h8,
        PERDE_VIDA           = 4'h9,
        ESPERA_RETOMADA      = 4'hA,
        FINAL_TIMEOUT        = 4'hD,
        FINAL_ACERTOU        = 4'hE,
        FINAL_ERROU          = 4'hF
    } estado_t;

    // Shown on db_estado when the state register holds an unused code.
    localparam logic [3:0] ESTADO_INVALIDO = 4'hB;

    // Smallest r with 2**r >= valor.
    function automatic int clog2(input int valor);
        int r;
        r = 0;
        while ((1 << r) < valor) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/unidade_controle_modos_vidas.sv
// Life counter, loss-cause flag and difficulty-mode latch for the game
// control unit. The final-level target (alvo) is derived from the latched
// mode so a mode change mid-game has no effect.
module controle_vidas
    import unidade_controle_modos_pkg::*;
#(
    parameter int N_SEQ  = 16,
    parameter int ADDR_W = 4,
    parameter int MODE_W = 2,
    parameter int LIVES  = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          carrega,
    input  logic                          decrementa,
    input  logic                          marca_causa,
    input  logic                          causa_timeout_in,
    input  logic [MODE_W-1:0]             modo,
    output logic [clog2(LIVES+1)-1:0]     vidas,
    output logic                          causa,
    output logic [MODE_W-1:0]             db_modo,
    output logic [ADDR_W-1:0]             alvo
);

    localparam int VW = clog2(LIVES + 1);

    logic [VW-1:0]     vidas_q, vidas_d;
    logic              causa_q, causa_d;
    logic [MODE_W-1:0] modo_q, modo_d;

    // Next-value logic: reload at game start, saturating decrement on a loss,
    // cause captured on the cycle the FSM enters perde_vida.
    always_comb begin
        vidas_d = vidas_q;
        causa_d = causa_q;
        modo_d  = modo_q;
        if (carrega) begin
            vidas_d = VW'(LIVES);
            modo_d  = modo;
        end else if (decrementa && (vidas_q != '0)) begin
            vidas_d = vidas_q - 1'b1;
        end
        if (marca_causa) begin
            causa_d = causa_timeout_in;
        end
    end

    // Registers with asynchronous active-low reset to a full life count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vidas_q <= VW'(LIVES);
            causa_q <= 1'b0;
            modo_q  <= '0;
        end else begin
            vidas_q <= vidas_d;
            causa_q <= causa_d;
            modo_q  <= modo_d;
        end
    end

    // Target level: last index of the (modo+1)-th fraction of the sequence.
    always_comb begin
        alvo = ADDR_W'((((int'(modo_q) + 1) * N_SEQ) >> MODE_W) - 1);
    end

    assign vidas   = vidas_q;
    assign causa   = causa_q;
    assign db_modo = modo_q;

endmodule

// File: rtl/unidade_controle_modos.sv
// Game-sequencer control unit with selectable difficulty and retry lives.
// Moore FSM driving the E/L/R/T datapath handshake; the life counter and
// mode latch live in controle_vidas.
module unidade_controle_modos
    import unidade_controle_modos_pkg::*;
#(
    parameter int N_SEQ  = 16,
    parameter int ADDR_W = 4,
    parameter int MODE_W = 2,
    parameter int LIVES  = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      jogada,
    input  logic                      timeout,
    input  logic                      botoesIgualMemoria,
    input  logic                      enderecoIgualLimite,
    input  logic                      enderecoMenorLimite,
    input  logic [ADDR_W-1:0]         nivel,
    input  logic [MODE_W-1:0]         modo,
    output logic                      zeraE,
    output logic                      contaE,
    output logic                      zeraL,
    output logic                      contaL,
    output logic                      zeraR,
    output logic                      registraR,
    output logic                      zeraT,
    output logic                      contaT,
    output logic                      acertou,
    output logic                      errou,
    output logic                      perdeu_tempo,
    output logic                      pronto,
    output logic [clog2(LIVES+1)-1:0] vidas,
    output logic [MODE_W-1:0]         db_modo,
    output logic [3:0]                db_estado
);

    localparam int VW = clog2(LIVES + 1);

    estado_t           estado_q, estado_d;
    logic              carrega;
    logic              decrementa;
    logic              marca_causa;
    logic              causa_timeout_in;
    logic              causa;
    logic [ADDR_W-1:0] alvo;
    logic              ultimo_nivel;

    controle_vidas #(
        .N_SEQ  (N_SEQ),
        .ADDR_W (ADDR_W),
        .MODE_W (MODE_W),
        .LIVES  (LIVES)
    ) u_vidas (
        .clock            (clock),
        .reset            (reset),
        .carrega          (carrega),
        .decrementa       (decrementa),
        .marca_causa      (marca_causa),
        .causa_timeout_in (causa_timeout_in),
        .modo             (modo),
        .vidas            (vidas),
        .causa            (causa),
        .db_modo          (db_modo),
        .alvo             (alvo)
    );

    // The game ends at the mode's target level, or at the last sequence
    // entry regardless of mode.
    assign ultimo_nivel = (nivel == alvo) || (nivel == ADDR_W'(N_SEQ - 1));

    // Life controller hooks: reload in preparacao, decrement while leaving
    // perde_vida, and record the cause on the cycle we enter perde_vida.
    assign carrega          = (estado_q == PREPARACAO);
    assign decrementa       = (estado_q == PERDE_VIDA);
    assign marca_causa      = (estado_d == PERDE_VIDA) && (estado_q != PERDE_VIDA);
    assign causa_timeout_in = (estado_q == ESPERA_JOGADA);

    // State register, asynchronous active-low reset to inicial.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO:       estado_d = INICIA_SEQUENCIA;
            INICIA_SEQUENCIA: estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A press in the same cycle as the timeout still counts.
                if (jogada)       estado_d = REGISTRA_JOGADA;
                else if (timeout) estado_d = PERDE_VIDA;
            end
            REGISTRA_JOGADA:  estado_d = COMPARA_JOGADA;
            COMPARA_JOGADA: begin
                if (botoesIgualMemoria && enderecoMenorLimite)      estado_d = PROXIMA_JOGADA;
                else if (botoesIgualMemoria && enderecoIgualLimite) estado_d = FOI_ULTIMA_SEQUENCIA;
                else                                                estado_d = PERDE_VIDA;
            end
            PROXIMA_JOGADA:   estado_d = ESPERA_JOGADA;
            FOI_ULTIMA_SEQUENCIA: begin
                if (ultimo_nivel) estado_d = FINAL_ACERTOU;
                else              estado_d = PROXIMA_SEQUENCIA;
            end
            PROXIMA_SEQUENCIA: estado_d = INICIA_SEQUENCIA;
            PERDE_VIDA: begin
                // Last life spent: report how it was lost.
                if (vidas == VW'(1)) estado_d = causa ? FINAL_TIMEOUT : FINAL_ERROU;
                else                 estado_d = ESPERA_RETOMADA;
            end
            ESPERA_RETOMADA: begin
                // Resume replays the current level; L is left untouched.
                if (iniciar) estado_d = INICIA_SEQUENCIA;
            end
            FINAL_TIMEOUT, FINAL_ACERTOU, FINAL_ERROU: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            default:          estado_d = INICIAL;
        endcase
    end

    // Moore output decode of the state register.
    always_comb begin
        zeraE        = 1'b0;
        contaE       = 1'b0;
        zeraL        = 1'b0;
        contaL       = 1'b0;
        zeraR        = 1'b0;
        registraR    = 1'b0;
        zeraT        = 1'b1;
        contaT       = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        perdeu_tempo = 1'b0;
        pronto       = 1'b0;
        db_estado    = estado_q;
        case (estado_q)
            INICIAL, PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
            end
            INICIA_SEQUENCIA, COMPARA_JOGADA, FOI_ULTIMA_SEQUENCIA, PERDE_VIDA: begin
            end
            ESPERA_JOGADA: begin
                zeraT  = 1'b0;
                contaT = 1'b1;
            end
            REGISTRA_JOGADA:   registraR = 1'b1;
            PROXIMA_JOGADA:    contaE    = 1'b1;
            PROXIMA_SEQUENCIA: begin
                zeraE  = 1'b1;
                contaL = 1'b1;
            end
            ESPERA_RETOMADA:   zeraE = 1'b1;
            FINAL_TIMEOUT: begin
                perdeu_tempo = 1'b1;
                pronto       = 1'b1;
            end
            FINAL_ACERTOU: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FINAL_ERROU: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            default:           db_estado = ESTADO_INVALIDO;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_modos.sv
// Bench for unidade_controle_modos: instance 0 uses LIVES=3, instance 1 uses
// LIVES=1. A small E/L datapath reacts to each DUT's controls, a game-rules
// model predicts every output each cycle, and directed games add literal checks.
module tb_unidade_controle_modos;

    localparam int N_SEQ = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       iniciar [2];
    logic       jogada  [2];
    logic       tmo     [2];
    logic       bim     [2];
    logic [1:0] modo_i  [2];
    logic [3:0] e_q     [2];
    logic [3:0] l_q     [2];

    logic [11:0] outv  [2];
    logic [1:0]  vid_o [2];
    logic [1:0]  dmo   [2];
    logic [3:0]  dst   [2];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int m_st [2];
    int m_vid [2];
    int m_modo [2];
    int m_causa [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LV = (g == 0) ? 3 : 1;
        localparam int VW = (g == 0) ? 2 : 1;
        logic zE, cE, zL, cL, zR, rR, zT, cT, ac, er, pt, pr;
        logic [VW-1:0] v;
        logic [1:0]    dm;
        logic [3:0]    de;
        unidade_controle_modos #(
            .N_SEQ(16), .ADDR_W(4), .MODE_W(2), .LIVES(LV)
        ) u_dut (
            .clock               (clock),
            .reset               (reset),
            .iniciar             (iniciar[g]),
            .jogada              (jogada[g]),
            .timeout             (tmo[g]),
            .botoesIgualMemoria  (bim[g]),
            .enderecoIgualLimite (e_q[g] == l_q[g]),
            .enderecoMenorLimite (e_q[g] < l_q[g]),
            .nivel               (l_q[g]),
            .modo                (modo_i[g]),
            .zeraE               (zE),
            .contaE              (cE),
            .zeraL               (zL),
            .contaL              (cL),
            .zeraR               (zR),
            .registraR           (rR),
            .zeraT               (zT),
            .contaT              (cT),
            .acertou             (ac),
            .errou               (er),
            .perdeu_tempo        (pt),
            .pronto              (pr),
            .vidas               (v),
            .db_modo             (dm),
            .db_estado           (de)
        );
        assign outv[g]  = {zE, cE, zL, cL, zR, rR, zT, cT, ac, er, pt, pr};
        assign vid_o[g] = 2'(v);
        assign dmo[g]   = dm;
        assign dst[g]   = de;
    end

    // Datapath stand-in: address and limit counters driven by the controls.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset || outv[k][11])  e_q[k] <= 4'd0;
            else if (outv[k][10])       e_q[k] <= 4'(e_q[k] + 1);
            if (!reset || outv[k][9])   l_q[k] <= 4'd0;
            else if (outv[k][8])        l_q[k] <= 4'(l_q[k] + 1);
        end
    end

    function automatic int lives_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    // Final level for a mode: the sequence is split into four equal slices.
    function automatic int alvo_of(input int md);
        return (N_SEQ / 4) * (md + 1) - 1;
    endfunction

    function automatic void step(input int k, output int ns, output int nv,
                                 output int nm, output int nc);
        int st;
        st = m_st[k];
        ns = st;
        nv = m_vid[k];
        nm = m_modo[k];
        nc = m_causa[k];
        case (st)
            0: if (iniciar[k]) ns = 1;
            1: begin ns = 2; nm = int'(modo_i[k]); nv = lives_of(k); end
            2: ns = 3;
            3: begin
                if (jogada[k]) ns = 4;
                else if (tmo[k]) begin ns = 9; nc = 1; end
            end
            4: ns = 5;
            5: begin
                if (bim[k] && (e_q[k] < l_q[k]))       ns = 6;
                else if (bim[k] && (e_q[k] == l_q[k])) ns = 7;
                else begin ns = 9; nc = 0; end
            end
            6: ns = 3;
            7: ns = ((int'(l_q[k]) == alvo_of(m_modo[k])) || (int'(l_q[k]) == N_SEQ - 1)) ? 14 : 8;
            8: ns = 2;
            9: begin
                ns = (m_vid[k] == 1) ? ((m_causa[k] != 0) ? 13 : 15) : 10;
                if (nv > 0) nv = nv - 1;
            end
            10: if (iniciar[k]) ns = 2;
            13, 14, 15: if (iniciar[k]) ns = 1;
            default: ns = 0;
        endcase
    endfunction

    // Rules model: one abstract game state per instance.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k]    <= 0;
                m_vid[k]   <= lives_of(k);
                m_modo[k]  <= 0;
                m_causa[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int ns, nv, nm, nc;
                step(k, ns, nv, nm, nc);
                m_st[k]    <= ns;
                m_vid[k]   <= nv;
                m_modo[k]  <= nm;
                m_causa[k] <= nc;
            end
        end
    end

    // Expected control outputs for a game state, bit order as outv.
    function automatic logic [11:0] exp_out(input int st);
        logic [11:0] e;
        e[11] = st inside {0, 1, 8, 10};
        e[10] = (st == 6);
        e[9]  = st inside {0, 1};
        e[8]  = (st == 8);
        e[7]  = st inside {0, 1};
        e[6]  = (st == 4);
        e[5]  = (st != 3);
        e[4]  = (st == 3);
        e[3]  = (st == 14);
        e[2]  = (st == 15);
        e[1]  = (st == 13);
        e[0]  = (st >= 13);
        return e;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if ((outv[k] !== exp_out(m_st[k])) || (dst[k] !== 4'(m_st[k])) ||
                    (vid_o[k] !== 2'(m_vid[k])) || (dmo[k] !== 2'(m_modo[k]))) begin
                    fails++;
                    $display("FAIL model[%0d] t=%0t: got state %h outs %b vidas %0d modo %0d, required state %h outs %b vidas %0d modo %0d",
                             k, $time, dst[k], outv[k], vid_o[k], dmo[k],
                             4'(m_st[k]), exp_out(m_st[k]), m_vid[k], m_modo[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_st(input int k, input int code, input int budget);
        int n;
        n = 0;
        while ((m_st[k] != code) && (n < budget)) begin
            tick();
            n++;
        end
        if (m_st[k] != code) begin
            tests++;
            fails++;
            $display("FAIL wait_state[%0d]: got state %0d, required %0d", k, m_st[k], code);
        end
    endtask

    task automatic start_game(input int k, input int md);
        modo_i[k]  = 2'(md);
        iniciar[k] = 1'b1;
        tick();
        iniciar[k] = 1'b0;
        wait_st(k, 3, 8);
    endtask

    task automatic press(input int k, input bit ok);
        jogada[k] = 1'b1;
        bim[k]    = ok;
        tick();
        jogada[k] = 1'b0;
        tick();
        tick();
        bim[k]    = 1'b0;
    endtask

    task automatic timeout_once(input int k);
        tmo[k] = 1'b1;
        tick();
        tmo[k] = 1'b0;
        tick();
    endtask

    task automatic resume(input int k);
        iniciar[k] = 1'b1;
        tick();
        iniciar[k] = 1'b0;
        tick();
    endtask

    task automatic play_to_end(input int k, input int budget);
        int n;
        n = 0;
        while (!(m_st[k] inside {10, 13, 14, 15}) && (n < budget)) begin
            if (m_st[k] == 3) press(k, 1'b1);
            else              tick();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL play_budget[%0d]: game still in state %0d", k, m_st[k]);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            iniciar[k] = 1'b0;
            jogada[k]  = 1'b0;
            tmo[k]     = 1'b0;
            bim[k]     = 1'b0;
            modo_i[k]  = 2'd0;
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_estado", int'(dst[0]), 0);
        chk("rst_vidas", int'(vid_o[0]), 3);
        chk("rst_zeras", int'(outv[0]), 12'b1010_1010_0000);
        chk("rst_vidas_l1", int'(vid_o[1]), 1);
        reset = 1'b1;
        tick();

        // Mode 0: four levels, success at nivel 3.
        start_game(0, 0);
        play_to_end(0, 400);
        chk("A_estado", int'(dst[0]), 14);
        chk("A_acertou", int'(outv[0][3]), 1);
        chk("A_pronto", int'(outv[0][0]), 1);
        chk("A_nivel", int'(l_q[0]), 3);

        // Mode 3, with a later modo change that must be ignored.
        start_game(0, 3);
        modo_i[0] = 2'd0;
        play_to_end(0, 3000);
        chk("B_estado", int'(dst[0]), 14);
        chk("B_nivel", int'(l_q[0]), 15);
        chk("B_db_modo", int'(dmo[0]), 3);

        // Mode 1: error at level 2, resume, simultaneous press/timeout, timeouts.
        start_game(0, 1);
        n = 0;
        while (!((m_st[0] == 3) && (l_q[0] == 4'd2)) && (n < 200)) begin
            if (m_st[0] == 3) press(0, 1'b1);
            else              tick();
            n++;
        end
        chk("C_nivel2", int'(l_q[0]), 2);
        press(0, 1'b0);
        chk("C_perde_vida", int'(dst[0]), 9);
        tick();
        chk("C_retomada", int'(dst[0]), 10);
        chk("C_vidas2", int'(vid_o[0]), 2);
        chk("C_nivel_mantido", int'(l_q[0]), 2);
        chk("C_zeraE", int'(outv[0][11]), 1);
        iniciar[0] = 1'b1;
        tick();
        iniciar[0] = 1'b0;
        chk("C_reinicia", int'(dst[0]), 2);
        tick();
        jogada[0] = 1'b1;
        tmo[0]    = 1'b1;
        tick();
        jogada[0] = 1'b0;
        tmo[0]    = 1'b0;
        chk("C_simultaneo", int'(dst[0]), 4);
        chk("C_simult_vidas", int'(vid_o[0]), 2);
        bim[0] = 1'b1;
        tick();
        tick();
        bim[0] = 1'b0;
        chk("C_proxima", int'(dst[0]), 6);
        tick();
        timeout_once(0);
        chk("C_retomada2", int'(dst[0]), 10);
        chk("C_vidas1", int'(vid_o[0]), 1);
        resume(0);
        timeout_once(0);
        chk("C_final_timeout", int'(dst[0]), 13);
        chk("C_vidas0", int'(vid_o[0]), 0);

        // Three timeouts in a fresh game.
        start_game(0, 0);
        timeout_once(0);
        chk("D_vidas2", int'(vid_o[0]), 2);
        resume(0);
        timeout_once(0);
        chk("D_vidas1", int'(vid_o[0]), 1);
        resume(0);
        timeout_once(0);
        chk("D_estado", int'(dst[0]), 13);
        chk("D_perdeu_tempo", int'(outv[0][1]), 1);
        chk("D_errou", int'(outv[0][2]), 0);
        chk("D_vidas0", int'(vid_o[0]), 0);

        // Reset in the middle of espera_jogada acts immediately.
        start_game(0, 2);
        #2 reset = 1'b0;
        #1;
        chk("E_rst_estado", int'(dst[0]), 0);
        chk("E_rst_vidas", int'(vid_o[0]), 3);
        chk("E_rst_zeras", int'(outv[0]), 12'b1010_1010_0000);
        chk("E_rst_modo", int'(dmo[0]), 0);
        tick();
        reset = 1'b1;
        tick();

        // Single-life instance: one error ends the game, then a new game.
        start_game(1, 2);
        press(1, 1'b0);
        chk("F_perde_vida", int'(dst[1]), 9);
        tick();
        chk("F_final_errou", int'(dst[1]), 15);
        chk("F_errou", int'(outv[1][2]), 1);
        chk("F_vidas0", int'(vid_o[1]), 0);
        modo_i[1]  = 2'd1;
        iniciar[1] = 1'b1;
        tick();
        iniciar[1] = 1'b0;
        chk("F_preparacao", int'(dst[1]), 1);
        tick();
        chk("F_inicia", int'(dst[1]), 2);
        chk("F_vidas_recarga", int'(vid_o[1]), 1);
        chk("F_db_modo", int'(dmo[1]), 1);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unidade_controle_modos.md
Name: unidade_controle_modos

Overview:
Parametrised successor of the game-sequencer control unit. It drives the same datapath handshake: address counter E, limit counter L, button register R and timeout counter T. It adds a MODE_W-bit difficulty mode that selects the final sequence length, and a life counter so errors and timeouts can be retried. It sits between the top-level game wrapper and the datapath, replacing the fixed two-level control unit.

Parameters:
N_SEQ, 16, maximum sequence length; must be a multiple of 2**MODE_W.
ADDR_W, 4, width of the datapath level value; 2**ADDR_W >= N_SEQ.
MODE_W, 2, width of the difficulty mode input.
LIVES, 3, lives per game, >=1; LIVES=1 gives the legacy single-try behaviour.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start / resume request
jogada  in  1  button-press edge detected by the datapath
timeout  in  1  timeout counter expired
botoesIgualMemoria  in  1  registered buttons match memory
enderecoIgualLimite  in  1  E == L
enderecoMenorLimite  in  1  E < L
nivel  in  ADDR_W  current value of limit counter L
modo  in  MODE_W  difficulty selection, sampled only in preparacao
zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT  out  1 each  datapath controls
acertou  out  1  high in final_acertou
errou  out  1  high in final_errou
perdeu_tempo  out  1  high in final_timeout
pronto  out  1  high in any final state
vidas  out  clog2(LIVES+1)  remaining lives
db_modo  out  MODE_W  latched mode
db_estado  out  4  state code

Behaviour:
- Moore FSM: registered state; all outputs except vidas and db_modo are combinational decodes of the state register.
- State codes:
  - inicial=0, preparacao=1, inicia_sequencia=2, espera_jogada=3, registra_jogada=4, compara_jogada=5
  - proxima_jogada=6, foi_ultima_sequencia=7, proxima_sequencia=8, perde_vida=9, espera_retomada=A
  - final_timeout=D, final_acertou=E, final_errou=F
  - Unused codes map to inicial; db_estado shows B for them.
- Reset (reset=0, immediate, including mid-game):
  - state=inicial, vidas=LIVES, db_modo=0.
  - Outputs in inicial: zeraE=zeraL=zeraR=zeraT=1, all other controls 0.
- Transitions:
  - inicial: iniciar -> preparacao.
  - preparacao -> inicia_sequencia; latch modo; load vidas=LIVES.
  - inicia_sequencia -> espera_jogada.
  - espera_jogada: jogada -> registra_jogada; else timeout -> perde_vida; else stay. If jogada and timeout are asserted in the same cycle, jogada wins.
  - registra_jogada -> compara_jogada.
  - compara_jogada: match && E<L -> proxima_jogada; match && E==L -> foi_ultima_sequencia; otherwise -> perde_vida.
  - proxima_jogada -> espera_jogada.
  - foi_ultima_sequencia: nivel==alvo or nivel==N_SEQ-1 -> final_acertou; else -> proxima_sequencia.
  - proxima_sequencia -> inicia_sequencia.
  - perde_vida: vidas decrements on exit. If vidas==1 on entry, go to final_errou (cause=error) or final_timeout (cause=timeout); vidas becomes 0. Otherwise go to espera_retomada.
  - espera_retomada: iniciar -> inicia_sequencia, replaying the same level (L is not reset).
  - final_*: iniciar -> preparacao (new game, modo re-sampled).
- Cause flag: a 1-bit register set to 1 on the perde_vida entry from espera_jogada timeout, 0 on entry from compara_jogada. It resets to 0.
- alvo = ((db_modo+1)*N_SEQ >> MODE_W) - 1, width ADDR_W. Example with defaults: modo 0..3 -> alvo 3, 7, 11, 15.
- Output decodes:
  - zeraE: inicial, preparacao, proxima_sequencia, espera_retomada.
  - zeraL and zeraR: inicial, preparacao.
  - zeraT: every state except espera_jogada.
  - contaT: espera_jogada.
  - contaE: proxima_jogada.
  - contaL: proxima_sequencia.
  - registraR: registra_jogada.
  - pronto: D, E, F.
- vidas never underflows below 0 and never exceeds LIVES.
- A modo change after preparacao has no effect.

Decomposition:
- Shared package holds the state encodings, the db_estado error code B and the clog2 function.
- One sub-module, controle_vidas: the life counter, cause flag and mode latch, with alvo computed from the latched mode.
- The FSM stays in unidade_controle_modos.

Test Plan:
- Reset low during espera_jogada -> state=0 and vidas=3 while reset is low; zeraE=zeraL=zeraR=zeraT=1.
- modo=0, four correct rounds (nivel reaches 3) -> final_acertou, db_estado=E, acertou=1, pronto=1. Repeat with modo=3 -> success only at nivel=15.
- Wrong button at level 2 with LIVES=3 -> perde_vida, then espera_retomada (A) with vidas=2 and L unchanged. iniciar -> state 2, zeraE pulsed.
- Three consecutive timeouts -> vidas 3→2→1→0; third goes to final_timeout (D) with perdeu_tempo=1 and errou=0.
- jogada and timeout asserted in the same cycle in espera_jogada -> next state registra_jogada (4), vidas unchanged.
- LIVES=1 build, single error -> direct perde_vida → final_errou (F). iniciar from F -> preparacao with vidas reloaded to 1 and new modo latched.
